// File: rtl/id_stage_fwd_pkg.sv
// Purpose: shared decode types, opcode constants and control decode for the ID stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: fwd_sel_t, operand mux selects, rv32i_control_word, uses_rs1/uses_rs2, control_rom.
package id_pkg;

  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_t;

  typedef enum logic {ALU1_RS1, ALU1_PC} alumux1_sel_t;
  typedef enum logic [2:0] {ALU2_I, ALU2_U, ALU2_B, ALU2_S, ALU2_J, ALU2_RS2} alumux2_sel_t;
  typedef enum logic {CMP_RS2, CMP_I} cmpmux_sel_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef struct packed {
    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    alumux1_sel_t alumux1_sel;
    alumux2_sel_t alumux2_sel;
    cmpmux_sel_t  cmpmux_sel;
    logic         load_regfile;
    logic         mem_read;
    logic         mem_write;
    logic [4:0]   rd;
  } rv32i_control_word;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_REG) || (op == OP_STORE) || (op == OP_BR);
  endfunction

  function automatic rv32i_control_word control_rom(input logic [31:0] instr);
    rv32i_control_word cw;
    cw             = '0;
    cw.opcode      = instr[6:0];
    cw.funct3      = instr[14:12];
    cw.funct7      = instr[31:25];
    cw.rd          = instr[11:7];
    cw.alumux1_sel = ALU1_RS1;
    cw.alumux2_sel = ALU2_I;
    cw.cmpmux_sel  = CMP_RS2;
    case (instr[6:0])
      OP_LUI: begin
        cw.alumux2_sel  = ALU2_U;
        cw.load_regfile = 1'b1;
      end
      OP_AUIPC: begin
        cw.alumux1_sel  = ALU1_PC;
        cw.alumux2_sel  = ALU2_U;
        cw.load_regfile = 1'b1;
      end
      OP_JAL: begin
        cw.alumux1_sel  = ALU1_PC;
        cw.alumux2_sel  = ALU2_J;
        cw.load_regfile = 1'b1;
      end
      OP_JALR: cw.load_regfile = 1'b1;
      OP_BR: begin
        cw.alumux1_sel = ALU1_PC;
        cw.alumux2_sel = ALU2_B;
      end
      OP_LOAD: begin
        cw.load_regfile = 1'b1;
        cw.mem_read     = 1'b1;
      end
      OP_STORE: begin
        cw.alumux2_sel = ALU2_S;
        cw.mem_write   = 1'b1;
      end
      OP_IMM: begin
        cw.cmpmux_sel   = CMP_I;
        cw.load_regfile = 1'b1;
      end
      OP_REG: begin
        cw.alumux2_sel  = ALU2_RS2;
        cw.load_regfile = 1'b1;
      end
      default: ;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/id_stage_fwd_if.sv
// Purpose: fetch->ID handshake and ID/EX register bundle.
// Latency: n/a (wiring only).
// Backpressure: id_ready towards fetch, ex_ready from execute.
// master = fetch/execute side, slave = the ID stage.
interface id_stage_fwd_if #(parameter int XLEN = 32);
  import id_pkg::*;

  logic              if_valid;
  logic [XLEN-1:0]   if_pc;
  logic [31:0]       if_instr;
  logic              id_ready;
  logic              ex_ready;
  logic              idex_valid;
  rv32i_control_word idex_ctrl;
  logic [31:0]       idex_instr;
  logic [XLEN-1:0]   idex_pc;
  logic [XLEN-1:0]   idex_alu_in1;
  logic [XLEN-1:0]   idex_alu_in2;
  logic [XLEN-1:0]   idex_cmp_in;
  logic [XLEN-1:0]   idex_rs1;
  logic [XLEN-1:0]   idex_rs2;

  modport master (
    output if_valid, if_pc, if_instr, ex_ready,
    input  id_ready, idex_valid, idex_ctrl, idex_instr, idex_pc,
           idex_alu_in1, idex_alu_in2, idex_cmp_in, idex_rs1, idex_rs2
  );

  modport slave (
    input  if_valid, if_pc, if_instr, ex_ready,
    output id_ready, idex_valid, idex_ctrl, idex_instr, idex_pc,
           idex_alu_in1, idex_alu_in2, idex_cmp_in, idex_rs1, idex_rs2
  );
endinterface

// File: rtl/id_stage_fwd_fwd_unit.sv
// Purpose: per-source forward select and load-use hazard detection.
// Latency: combinational.
// Backpressure: none; hazard is consumed by the ID stage to stall fetch.
// Ports: rs1/rs2 (already zeroed when the opcode does not use them), stage rd/enables, ex_mem_read -> rs1_sel, rs2_sel, hazard.
module fwd_unit
  import id_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          if_valid,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] ex_rd,
  input  logic [RW-1:0] mem_rd,
  input  logic [RW-1:0] wb_rd,
  input  logic          ex_load_regfile,
  input  logic          mem_load_regfile,
  input  logic          wb_load_regfile,
  input  logic          ex_mem_read,
  output fwd_sel_t      rs1_sel,
  output fwd_sel_t      rs2_sel,
  output logic          hazard
);

  // Youngest producer wins. A load in EX has no data yet, so it is skipped
  // here and covered by the hazard bubble instead.
  function automatic fwd_sel_t pick(input logic [RW-1:0] rs);
    if (rs == '0) return FWD_RF;
    if (ex_load_regfile && !ex_mem_read && (ex_rd == rs)) return FWD_EX;
    if (mem_load_regfile && (mem_rd == rs)) return FWD_MEM;
    if (wb_load_regfile && (wb_rd == rs)) return FWD_WB;
    return FWD_RF;
  endfunction

  assign rs1_sel = pick(rs1);
  assign rs2_sel = pick(rs2);

  // Unused sources arrive as 0, so matching a nonzero ex_rd implies use.
  assign hazard = if_valid && ex_load_regfile && ex_mem_read && (ex_rd != '0) &&
                  ((ex_rd == rs1) || (ex_rd == rs2));

endmodule

// File: rtl/id_stage_fwd.sv
// Purpose: decode, regfile read with EX/MEM/WB forwarding, load-use bubbles, ID/EX register.
// Latency: one cycle from acceptance to idex_valid.
// Backpressure: ex_ready=0 holds ID/EX; load-use hazard drops id_ready; flush always accepts and kills.
// Ports: clk/rst, bus (slave: fetch handshake + idex_* outputs), flush, stage rd/enable/result, bubble_count.
module id_stage_fwd
  import id_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_fwd_if.slave    bus,
  input  logic             flush,
  input  logic [RW-1:0]    ex_rd,
  input  logic [RW-1:0]    mem_rd,
  input  logic [RW-1:0]    wb_rd,
  input  logic             ex_load_regfile,
  input  logic             mem_load_regfile,
  input  logic             wb_load_regfile,
  input  logic             ex_mem_read,
  input  logic [XLEN-1:0]  ex_result,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [XLEN-1:0]  wb_data,
  output logic [CNT_W-1:0] bubble_count
);

  logic [31:0]       instr;
  rv32i_control_word ctrl;
  logic [RW-1:0]     rs1_idx, rs2_idx;

  assign instr = bus.if_instr;
  assign ctrl  = control_rom(instr);

  // Unused sources are forced to x0 so they never forward or stall.
  assign rs1_idx = uses_rs1(instr[6:0]) ? instr[15 +: RW] : '0;
  assign rs2_idx = uses_rs2(instr[6:0]) ? instr[20 +: RW] : '0;

  // ---------------- register file (write-first) ----------------
  logic [XLEN-1:0] rf_q [NUM_REGS];
  logic [XLEN-1:0] rf_d [NUM_REGS];
  logic [XLEN-1:0] rf_rs1, rf_rs2;

  always_comb begin
    rf_d = rf_q;
    if (wb_load_regfile && (wb_rd != '0)) rf_d[wb_rd] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rf_rs1 = '0;
    rf_rs2 = '0;
    if (rs1_idx != '0)
      rf_rs1 = (wb_load_regfile && (wb_rd == rs1_idx)) ? wb_data : rf_q[rs1_idx];
    if (rs2_idx != '0)
      rf_rs2 = (wb_load_regfile && (wb_rd == rs2_idx)) ? wb_data : rf_q[rs2_idx];
  end

  // ---------------- forwarding ----------------
  fwd_sel_t rs1_sel, rs2_sel;
  logic     hazard;

  fwd_unit #(.RW(RW)) u_fwd (
    .if_valid         (bus.if_valid),
    .rs1              (rs1_idx),
    .rs2              (rs2_idx),
    .ex_rd            (ex_rd),
    .mem_rd           (mem_rd),
    .wb_rd            (wb_rd),
    .ex_load_regfile  (ex_load_regfile),
    .mem_load_regfile (mem_load_regfile),
    .wb_load_regfile  (wb_load_regfile),
    .ex_mem_read      (ex_mem_read),
    .rs1_sel          (rs1_sel),
    .rs2_sel          (rs2_sel),
    .hazard           (hazard)
  );

  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    case (rs1_sel)
      FWD_EX:  rs1_val = ex_result;
      FWD_MEM: rs1_val = mem_result;
      FWD_WB:  rs1_val = wb_data;
      default: rs1_val = rf_rs1;
    endcase
    case (rs2_sel)
      FWD_EX:  rs2_val = ex_result;
      FWD_MEM: rs2_val = mem_result;
      FWD_WB:  rs2_val = wb_data;
      default: rs2_val = rf_rs2;
    endcase
  end

  // ---------------- immediates and operand muxes ----------------
  logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [XLEN-1:0] alu_in1, alu_in2, cmp_in;

  assign i_imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
  assign s_imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
  assign b_imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'h000};
  assign j_imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    alu_in1 = (ctrl.alumux1_sel == ALU1_PC) ? bus.if_pc : rs1_val;
    case (ctrl.alumux2_sel)
      ALU2_I:  alu_in2 = i_imm;
      ALU2_U:  alu_in2 = u_imm;
      ALU2_B:  alu_in2 = b_imm;
      ALU2_S:  alu_in2 = s_imm;
      ALU2_J:  alu_in2 = j_imm;
      default: alu_in2 = rs2_val;
    endcase
    cmp_in = (ctrl.cmpmux_sel == CMP_I) ? i_imm : rs2_val;
  end

  // ---------------- ID/EX register ----------------
  logic              idex_valid_q,   idex_valid_d;
  rv32i_control_word idex_ctrl_q,    idex_ctrl_d;
  logic [31:0]       idex_instr_q,   idex_instr_d;
  logic [XLEN-1:0]   idex_pc_q,      idex_pc_d;
  logic [XLEN-1:0]   idex_alu_in1_q, idex_alu_in1_d;
  logic [XLEN-1:0]   idex_alu_in2_q, idex_alu_in2_d;
  logic [XLEN-1:0]   idex_cmp_in_q,  idex_cmp_in_d;
  logic [XLEN-1:0]   idex_rs1_q,     idex_rs1_d;
  logic [XLEN-1:0]   idex_rs2_q,     idex_rs2_d;
  logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

  always_comb begin
    idex_valid_d   = idex_valid_q;
    idex_ctrl_d    = idex_ctrl_q;
    idex_instr_d   = idex_instr_q;
    idex_pc_d      = idex_pc_q;
    idex_alu_in1_d = idex_alu_in1_q;
    idex_alu_in2_d = idex_alu_in2_q;
    idex_cmp_in_d  = idex_cmp_in_q;
    idex_rs1_d     = idex_rs1_q;
    idex_rs2_d     = idex_rs2_q;
    bubble_count_d = bubble_count_q;
    if (flush) begin
      idex_valid_d = 1'b0;
    end else if (!bus.ex_ready) begin
      // EX is full: everything holds.
    end else if (hazard) begin
      idex_valid_d = 1'b0;
      if (bubble_count_q != '1) bubble_count_d = bubble_count_q + CNT_W'(1);
    end else begin
      // Fields load even with no instruction so the register stays deterministic.
      idex_valid_d   = bus.if_valid;
      idex_ctrl_d    = ctrl;
      idex_instr_d   = instr;
      idex_pc_d      = bus.if_pc;
      idex_alu_in1_d = alu_in1;
      idex_alu_in2_d = alu_in2;
      idex_cmp_in_d  = cmp_in;
      idex_rs1_d     = rs1_val;
      idex_rs2_d     = rs2_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_valid_q   <= 1'b0;
      idex_ctrl_q    <= '0;
      idex_instr_q   <= '0;
      idex_pc_q      <= '0;
      idex_alu_in1_q <= '0;
      idex_alu_in2_q <= '0;
      idex_cmp_in_q  <= '0;
      idex_rs1_q     <= '0;
      idex_rs2_q     <= '0;
      bubble_count_q <= '0;
    end else begin
      idex_valid_q   <= idex_valid_d;
      idex_ctrl_q    <= idex_ctrl_d;
      idex_instr_q   <= idex_instr_d;
      idex_pc_q      <= idex_pc_d;
      idex_alu_in1_q <= idex_alu_in1_d;
      idex_alu_in2_q <= idex_alu_in2_d;
      idex_cmp_in_q  <= idex_cmp_in_d;
      idex_rs1_q     <= idex_rs1_d;
      idex_rs2_q     <= idex_rs2_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.id_ready     = flush || (bus.ex_ready && !hazard);
  assign bus.idex_valid   = idex_valid_q;
  assign bus.idex_ctrl    = idex_ctrl_q;
  assign bus.idex_instr   = idex_instr_q;
  assign bus.idex_pc      = idex_pc_q;
  assign bus.idex_alu_in1 = idex_alu_in1_q;
  assign bus.idex_alu_in2 = idex_alu_in2_q;
  assign bus.idex_cmp_in  = idex_cmp_in_q;
  assign bus.idex_rs1     = idex_rs1_q;
  assign bus.idex_rs2     = idex_rs2_q;
  assign bubble_count     = bubble_count_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Purpose: scoreboard bench for id_stage_fwd (directed vectors, hand-computed operands).
// Latency: expected entries leave the scoreboard when EX consumes them.
// Backpressure: ex_ready and flush are driven directly by the stimulus.
module tb_id_stage_fwd;

  localparam logic [31:0] ADD3  = 32'h002081B3; // add  x3,x1,x2
  localparam logic [31:0] ADD5  = 32'h004202B3; // add  x5,x4,x4
  localparam logic [31:0] ADD6  = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] ADDI8 = 32'hFFF08413; // addi x8,x1,-1
  localparam logic [31:0] LUI9  = 32'h123454B7; // lui  x9,0x12345

  logic        clk, rst, flush;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_load_regfile, mem_load_regfile, wb_load_regfile, ex_mem_read;
  logic [31:0] ex_result, mem_result, wb_data;
  logic [1:0]  bubble_count;

  id_stage_fwd_if #(.XLEN(32)) bus ();

  id_stage_fwd #(.XLEN(32), .NUM_REGS(32), .CNT_W(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .flush            (flush),
    .ex_rd            (ex_rd),
    .mem_rd           (mem_rd),
    .wb_rd            (wb_rd),
    .ex_load_regfile  (ex_load_regfile),
    .mem_load_regfile (mem_load_regfile),
    .wb_load_regfile  (wb_load_regfile),
    .ex_mem_read      (ex_mem_read),
    .ex_result        (ex_result),
    .mem_result       (mem_result),
    .wb_data          (wb_data),
    .bubble_count     (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, instr, a1, a2, cmp, r1, r2;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0; bus.ex_ready = 1'b1;
    flush = 1'b0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_load_regfile = 1'b0; mem_load_regfile = 1'b0; wb_load_regfile = 1'b0;
    ex_mem_read = 1'b0; ex_result = '0; mem_result = '0; wb_data = '0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_valid = 1'b1; bus.if_pc = pc; bus.if_instr = instr;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] cmp,
                       input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e.pc = pc; e.instr = instr; e.a1 = a1; e.a2 = a2; e.cmp = cmp; e.r1 = r1; e.r2 = r2;
    sb.push_back(e);
    drive(pc, instr);
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] d);
    wb_load_regfile = 1'b1; wb_rd = rd; wb_data = d;
  endtask

  // Monitor: an entry is consumed on an edge where it is valid and EX is ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.idex_valid && bus.ex_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_entry actual_pc=%h required=none", bus.idex_pc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("pc%0h.pc", e.pc), bus.idex_pc, e.pc);
          chk($sformatf("pc%0h.instr", e.pc), bus.idex_instr, e.instr);
          chk($sformatf("pc%0h.ctrl_op_rd", e.pc), {20'd0, bus.idex_ctrl.opcode, bus.idex_ctrl.rd},
              {20'd0, e.instr[6:0], e.instr[11:7]});
          chk($sformatf("pc%0h.alu_in1", e.pc), bus.idex_alu_in1, e.a1);
          chk($sformatf("pc%0h.alu_in2", e.pc), bus.idex_alu_in2, e.a2);
          chk($sformatf("pc%0h.cmp_in", e.pc), bus.idex_cmp_in, e.cmp);
          chk($sformatf("pc%0h.rs1", e.pc), bus.idex_rs1, e.r1);
          chk($sformatf("pc%0h.rs2", e.pc), bus.idex_rs2, e.r2);
        end
      end
    end
  end

  int sat_exp[4] = '{2, 3, 3, 3};

  initial begin
    idle();
    rst = 1'b1;
    cyc(); cyc();
    chk("rst.idex_valid", {31'd0, bus.idex_valid}, 32'd0);
    chk("rst.idex_pc", bus.idex_pc, 32'd0);
    chk("rst.alu_in1", bus.idex_alu_in1, 32'd0);
    chk("rst.bubble_count", {30'd0, bubble_count}, 32'd0);
    rst = 1'b0;
    #1 chk("rst.id_ready", {31'd0, bus.id_ready}, 32'd1);

    // Preload x1=5, x2=7, x8=0xDEAD through WB.
    wb_write(5'd1, 32'd5);      cyc();
    wb_write(5'd2, 32'd7);      cyc();
    wb_write(5'd8, 32'hDEAD);   cyc();
    wb_load_regfile = 1'b0;

    // Back-to-back basic decode.
    issue(32'h100, ADD3, 32'd5, 32'd7, 32'd7, 32'd5, 32'd7);
    cyc();
    chk("add.idex_valid", {31'd0, bus.idex_valid}, 32'd1);
    issue(32'h104, ADDI8, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0);
    cyc();
    bus.if_valid = 1'b0;
    cyc();
    chk("idle.idex_valid", {31'd0, bus.idex_valid}, 32'd0);

    // Forward priority EX > MEM > WB on x1 (WB also commits 0x33 into x1).
    ex_rd = 5'd1; mem_rd = 5'd1; wb_rd = 5'd1;
    ex_load_regfile = 1'b1; mem_load_regfile = 1'b1; wb_load_regfile = 1'b1;
    ex_result = 32'h11; mem_result = 32'h22; wb_data = 32'h33;
    issue(32'h200, ADD3, 32'h11, 32'd7, 32'd7, 32'h11, 32'd7);
    cyc();
    ex_load_regfile = 1'b0;
    issue(32'h204, ADD3, 32'h22, 32'd7, 32'd7, 32'h22, 32'd7);
    cyc();
    mem_load_regfile = 1'b0;
    issue(32'h208, ADD3, 32'h33, 32'd7, 32'd7, 32'h33, 32'd7);
    cyc();
    idle(); cyc();

    // LUI does not use rs1 (field aliases x8): a load to x8 in EX must not stall it.
    ex_load_regfile = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8;
    issue(32'h300, LUI9, 32'd0, 32'h1234_5000, 32'd0, 32'd0, 32'd0);
    #1 chk("lui.id_ready", {31'd0, bus.id_ready}, 32'd1);
    cyc();
    idle(); cyc();
    chk("lui.bubble_count", {30'd0, bubble_count}, 32'd0);

    // Load-use: one bubble, then the load value forwards from MEM.
    ex_load_regfile = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; ex_result = 32'hBAD;
    issue(32'h400, ADD5, 32'h99, 32'h99, 32'h99, 32'h99, 32'h99);
    #1 chk("lu.id_ready", {31'd0, bus.id_ready}, 32'd0);
    cyc();
    chk("lu.bubble_valid", {31'd0, bus.idex_valid}, 32'd0);
    chk("lu.bubble_count", {30'd0, bubble_count}, 32'd1);
    ex_load_regfile = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_load_regfile = 1'b1; mem_rd = 5'd4; mem_result = 32'h99;
    #1 chk("lu.id_ready_after", {31'd0, bus.id_ready}, 32'd1);
    cyc();
    chk("lu.idex_valid", {31'd0, bus.idex_valid}, 32'd1);
    idle(); cyc();

    // EX stall for three cycles with an entry held and the next instruction waiting.
    issue(32'h500, ADD3, 32'h33, 32'd7, 32'd7, 32'h33, 32'd7);
    cyc();
    bus.ex_ready = 1'b0;
    issue(32'h504, ADDI8, 32'h33, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h33, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.id_ready", {31'd0, bus.id_ready}, 32'd0);
      cyc();
      chk("stall.idex_valid", {31'd0, bus.idex_valid}, 32'd1);
      chk("stall.idex_pc", bus.idex_pc, 32'h500);
      chk("stall.alu_in1", bus.idex_alu_in1, 32'h33);
    end
    bus.ex_ready = 1'b1;
    cyc();
    chk("stall.resume_pc", bus.idex_pc, 32'h504);
    idle(); cyc();

    // Flush beats both ex_ready=0 and an active hazard; the held entry is killed.
    drive(32'h600, ADD3);
    cyc();
    bus.ex_ready = 1'b0; flush = 1'b1;
    ex_load_regfile = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4;
    drive(32'h604, ADD5);
    #1 chk("flush.id_ready", {31'd0, bus.id_ready}, 32'd1);
    cyc();
    chk("flush.idex_valid", {31'd0, bus.idex_valid}, 32'd0);
    chk("flush.bubble_count", {30'd0, bubble_count}, 32'd1);
    idle(); cyc();

    // x0: writes ignored, forwards with rd=0 ignored, load to rd=0 never stalls.
    wb_write(5'd0, 32'hBAD);
    cyc();
    ex_load_regfile = 1'b1; ex_rd = 5'd0; ex_result = 32'hEE;
    mem_load_regfile = 1'b1; mem_rd = 5'd0; mem_result = 32'hEE;
    issue(32'h700, ADD6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    cyc();
    ex_mem_read = 1'b1;
    issue(32'h704, ADD6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    #1 chk("x0.id_ready", {31'd0, bus.id_ready}, 32'd1);
    cyc();
    idle(); cyc();

    // Bubble counter saturates at 3 with CNT_W=2.
    ex_load_regfile = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4;
    issue(32'h800, ADD5, 32'h55, 32'h55, 32'h55, 32'h55, 32'h55);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("sat.bubble_count%0d", i), {30'd0, bubble_count}, sat_exp[i]);
    end
    ex_load_regfile = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_load_regfile = 1'b1; mem_rd = 5'd4; mem_result = 32'h55;
    cyc();
    idle(); cyc();

    // Reset mid-operation drops the held entry and clears the regfile.
    drive(32'h900, ADD3);
    cyc();
    bus.ex_ready = 1'b0; bus.if_valid = 1'b0; rst = 1'b1;
    cyc();
    chk("rst2.idex_valid", {31'd0, bus.idex_valid}, 32'd0);
    chk("rst2.idex_pc", bus.idex_pc, 32'd0);
    chk("rst2.bubble_count", {30'd0, bubble_count}, 32'd0);
    rst = 1'b0; bus.ex_ready = 1'b1;
    issue(32'h904, ADD3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    cyc();
    idle(); cyc(); cyc();

    chk("sb.empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
- Parametrised successor to the current decode stage.
- Decodes the fetched instruction, reads the register file and resolves operands through an EX/MEM/WB forwarding network.
- Detects load-use hazards and inserts bubbles.
- Drives a valid/ready-controlled ID/EX pipeline register with flush support.
- Sits between instruction fetch (I-cache output) and execute; the regfile write port is driven from writeback.

Parameters:
XLEN, 32, datapath width of PC, operands and forwarded results
NUM_REGS, 32, architectural register count (index width RW = $clog2(NUM_REGS))
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
if_valid  input  1  if_pc/if_instr hold a valid instruction
if_pc  input  XLEN  PC of fetched instruction
if_instr  input  32  fetched instruction word
id_ready  output  1  ID accepts if_instr this cycle (IF may advance)
flush  input  1  branch/jump mispredict from EX; kill instruction in ID
ex_ready  input  1  EX can accept a new ID/EX entry this cycle
ex_rd, mem_rd, wb_rd  input  RW each  destination regs of EX, MEM, WB
ex_load_regfile, mem_load_regfile, wb_load_regfile  input  1 each  stage will write rd
ex_mem_read  input  1  EX instruction is a load
ex_result, mem_result, wb_data  input  XLEN each  forwardable results
idex_valid  output  1  ID/EX entry valid
idex_ctrl  output  rv32i_control_word  control word from control_rom
idex_instr  output  32  instruction
idex_pc  output  XLEN  PC
idex_alu_in1, idex_alu_in2, idex_cmp_in  output  XLEN each  selected ALU/CMP operands (post-forwarding)
idex_rs1, idex_rs2  output  XLEN each  forwarded rs1/rs2 values (store data, JALR base)
bubble_count  output  CNT_W  saturating count of load-use bubbles

Behaviour:
- Reset (rst=1 at an edge):
  - All idex_* outputs are 0; idex_valid=0; bubble_count=0.
  - All regfile entries are cleared.
  - Reset mid-operation discards any in-flight ID/EX entry.
- Regfile: x0 reads 0 and ignores writes.
  - WB write is write-first: same-cycle read of wb_rd returns wb_data.
- Source usage, decoded from the opcode:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by OP, STORE and BRANCH.
- Forward select, per used source:
  - Source 0 always yields 0 and never forwards.
  - Otherwise priority is EX (ex_load_regfile && !ex_mem_read && ex_rd==rs) > MEM > WB > regfile.
- Load-use hazard (hazard), combinational:
  - hazard = if_valid && ex_load_regfile && ex_mem_read && ex_rd!=0 && ex_rd matches a used source.
- Operand muxing:
  - alumux1/alumux2/cmpmux selects and immediates (i/s/b/u/j) are as in the existing decode.
  - reg_a/reg_b are replaced by the forwarded values.
- id_ready = ex_ready && !hazard, or flush=1.
- Per rising edge, first matching rule applies:
  1. flush: idex_valid<=0; the ID instruction is dropped (id_ready=1). Flush overrides ex_ready=0 and hazard.
  2. !ex_ready: all idex_* hold their values; forwarding keeps being recomputed on the held ID instruction.
  3. hazard: idex_valid<=0 (bubble); ID holds its instruction; bubble_count increments, saturating at 2^CNT_W-1.
  4. !if_valid: idex_valid<=0. Other idex fields are don't-care but stay deterministic (load them anyway).
  5. Otherwise: capture all idex_* with idex_valid<=1.
- Latency: one cycle from acceptance (if_valid && id_ready && !flush) to idex_valid.
- Throughput is one instruction per cycle absent hazards and stalls.
- A load-use pair costs exactly one bubble; the load is then in MEM, so the value forwards from mem_result.

Decomposition:
- Shared package id_pkg:
  - fwd_sel_t enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}.
  - Functions uses_rs1(opcode) and uses_rs2(opcode).
- Existing rv32i_types, alumux and cmpmux are reused unchanged.
- Sub-module fwd_unit (combinational): takes rs1, rs2, the stage rd/enable signals and ex_mem_read; outputs fwd_sel_t per source plus hazard.
- Existing regfile and control_rom are instantiated; regfile is wrapped for write-first bypass.

Test Plan:
- Reset, then single ADD x3,x1,x2 with x1=5, x2=7 preloaded via WB → next cycle idex_valid=1, idex_alu_in1=5, idex_alu_in2=7.
- EX/MEM/WB all writing x1 with values 0x11/0x22/0x33, ID reads x1 → alu_in1=0x11. Drop EX enable → 0x22. Drop MEM enable → 0x33.
- LW x4 in EX, ADD x5,x4,x4 in ID → id_ready=0, idex_valid=0 for one cycle, bubble_count=1. Next cycle mem_result=0x99 forwards → idex_rs1=idex_rs2=0x99.
- ex_ready=0 for 3 cycles with a valid entry → idex_* stable, id_ready=0. On release, capture resumes with no instruction lost.
- flush=1 while hazard active and ex_ready=0 → next edge idex_valid=0, id_ready=1, bubble_count unchanged.
- Writes to x0 and an EX forward with rd=0 → ID reading x0 gets 0. Also drive bubble_count past 2^CNT_W-1 (CNT_W=2) → it holds at 3.
